// File: rtl/button_debounce_pkg.sv
// ---------------------------------------------------------------------------
// button_debounce_pkg
//
// Shared definitions for the button debounce block.
//   - Default debounce lengths for silicon and for fast simulation.
//   - idle_level(): the resting pad level for a given button polarity.
//   - debounce_event_e: the event a channel reports when it accepts a level.
// ---------------------------------------------------------------------------
package button_debounce_pkg;

  // 20000 cycles is about 0.4 ms at 50 MHz, which covers typical contact bounce.
  localparam int DEBOUNCE_CYCLES_SILICON = 20000;
  localparam int DEBOUNCE_CYCLES_SIM     = 4;
  localparam int SYNC_STAGES_DEFAULT     = 2;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_PRESS   = 2'd1,
    EVT_RELEASE = 2'd2
  } debounce_event_e;

  // Active-low buttons rest at 1. Active-high buttons rest at 0.
  function automatic logic idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// ---------------------------------------------------------------------------
// button_debounce_if
//
// Bundles the button-side signals of the debouncer.
//   buttons_raw   : raw pad levels, asynchronous to clk
//   flag_clear    : per-bit clear request for the sticky press flags
//   buttons_clean : debounced levels, same polarity as the pads
//   press_pulse   : one-cycle pulse when a channel becomes active
//   release_pulse : one-cycle pulse when a channel becomes idle
//   press_flag    : sticky record of a press, cleared by flag_clear
//
// The master modport is the side that drives the pads and clears.
// The slave modport is the debouncer itself.
// ---------------------------------------------------------------------------
interface button_debounce_if #(
  parameter int N_BUTTONS = 2
);

  logic [N_BUTTONS-1:0] buttons_raw;
  logic [N_BUTTONS-1:0] flag_clear;
  logic [N_BUTTONS-1:0] buttons_clean;
  logic [N_BUTTONS-1:0] press_pulse;
  logic [N_BUTTONS-1:0] release_pulse;
  logic [N_BUTTONS-1:0] press_flag;

  modport master (
    output buttons_raw,
    output flag_clear,
    input  buttons_clean,
    input  press_pulse,
    input  release_pulse,
    input  press_flag
  );

  modport slave (
    input  buttons_raw,
    input  flag_clear,
    output buttons_clean,
    output press_pulse,
    output release_pulse,
    output press_flag
  );

endinterface

// File: rtl/button_debounce_channel.sv
// ---------------------------------------------------------------------------
// button_debounce_channel
//
// One debounced button. This module contains:
//   - a plain synchronizer chain,
//   - a stability counter,
//   - the accepted (clean) level,
//   - registered press/release pulses and a sticky press flag.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   raw_i           : raw pad level, asynchronous to clk
//   flag_clear_i    : synchronous clear of press_flag_o
//   clean_o         : debounced level, same polarity as the pad
//   press_pulse_o   : one-cycle pulse when the clean level becomes active
//   release_pulse_o : one-cycle pulse when the clean level becomes idle
//   press_flag_o    : sticky flag, set together with press_pulse_o
// ---------------------------------------------------------------------------
module button_debounce_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic flag_clear_i,
  output logic clean_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic press_flag_o
);

  import button_debounce_pkg::*;

  localparam logic IDLE = idle_level(ACTIVE_LOW);
  localparam int   CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter only reaches this value. The edge that would pass it
  // accepts the new level and restarts the count instead.
  localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   clean_q, clean_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   flag_q, flag_d;
  logic                   sync_s;
  debounce_event_e        evt;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // The counter runs only while the synchronized level differs from the
  // accepted level. Any return to the accepted level discards the partial
  // count, so a glitch never brings an acceptance closer.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], raw_i};
    count_d   = '0;
    clean_d   = clean_q;
    evt       = EVT_NONE;
    if (sync_s != clean_q) begin
      if (count_q == ACCEPT_AT) begin
        clean_d = sync_s;
        evt     = (sync_s == IDLE) ? EVT_RELEASE : EVT_PRESS;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
    press_d   = (evt == EVT_PRESS);
    release_d = (evt == EVT_RELEASE);
    // A new press wins over a clear in the same cycle, so no press is lost.
    flag_d    = press_d | (flag_q & ~flag_clear_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= {SYNC_STAGES{IDLE}};
      count_q   <= '0;
      clean_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      count_q   <= count_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      flag_q    <= flag_d;
    end
  end

  assign clean_o         = clean_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign press_flag_o    = flag_q;

endmodule

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// This is the input-conditioning stage in front of the Wishbone buttons/LEDs
// peripheral. Each raw pad button goes through its own independent debounce
// channel. The clean outputs keep the pad polarity, so the downstream
// peripheral still performs its own inversion.
//
// Ports:
//   clk   : system/wishbone clock
//   reset : asynchronous active-high reset
//   bus   : button_debounce_if.slave. It carries raw inputs, flag clears,
//           clean levels, pulses and flags, N_BUTTONS bits each.
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int N_BUTTONS       = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  button_debounce_if.slave    bus
);

  logic [N_BUTTONS-1:0] clean_vec;
  logic [N_BUTTONS-1:0] press_vec;
  logic [N_BUTTONS-1:0] release_vec;
  logic [N_BUTTONS-1:0] flag_vec;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    button_debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk             (clk),
      .reset           (reset),
      .raw_i           (bus.buttons_raw[i]),
      .flag_clear_i    (bus.flag_clear[i]),
      .clean_o         (clean_vec[i]),
      .press_pulse_o   (press_vec[i]),
      .release_pulse_o (release_vec[i]),
      .press_flag_o    (flag_vec[i])
    );
  end

  assign bus.buttons_clean = clean_vec;
  assign bus.press_pulse   = press_vec;
  assign bus.release_pulse = release_vec;
  assign bus.press_flag    = flag_vec;

endmodule
